// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Widths, the NOP encoding, the default halt opcode and the RUN/HALT state.
package if_stage_pkg;

    localparam int OP_W    = 4;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;
    localparam int OFF_W   = 6;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
    localparam logic [OP_W-1:0]    HALT_OP   = 4'hF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } if_state_e;

    // Signed word offset from ID, widened to a full PC.
    function automatic logic [PC_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
        return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Combinational next-PC selection: branch target, sequential increment or hold.
// The branch is relative to the instruction currently in ID (pc_out), not the fetch PC.
module if_pc_gen
    import if_stage_pkg::*;
(
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  pc_out_i,
    input  logic             branch_taken_i,
    input  logic [OFF_W-1:0] branch_offset_i,
    input  logic             advance_i,
    output logic [PC_W-1:0]  next_pc_o,
    output logic [PC_W-1:0]  target_o
);

    logic [PC_W-1:0] seq_pc;

    assign seq_pc   = pc_i + 16'd1;
    assign target_o = pc_out_i + 16'd1 + sext_offset(branch_offset_i);

    always_comb begin
        next_pc_o = pc_i;
        if (branch_taken_i) begin
            next_pc_o = target_o;
        end else if (advance_i) begin
            next_pc_o = seq_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, RUN/HALT control and the IF/ID output registers.
// Memory is external and combinational; imem_addr is the current PC.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = if_stage_pkg::HALT_OP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [5:0]  branch_offset_imm,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic        halted
);
    import if_stage_pkg::*;

    if_state_e           state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [PC_W-1:0]     pc_out_q, pc_out_d;
    logic [PC_W-1:0]     branch_target;
    logic                halt_fetch;
    logic                advance;

    assign halt_fetch = (state_q == RUN) && (opcode_of(imem_rdata) == HALT_OP);
    assign advance    = !stall && (state_q == RUN) && !halt_fetch;

    if_pc_gen u_pc_gen (
        .pc_i            (pc_q),
        .pc_out_i        (pc_out_q),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset_imm),
        .advance_i       (advance),
        .next_pc_o       (pc_d),
        .target_o        (branch_target)
    );

    // A branch squashes whatever was fetched this cycle, including a HALT opcode.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        if (branch_taken) begin
            state_d  = RUN;
            instr_d  = NOP_INSTR;
            pc_out_d = branch_target;
        end else if (!stall) begin
            if (state_q == RUN) begin
                instr_d  = imem_rdata;
                pc_out_d = pc_q;
                if (halt_fetch) begin
                    state_d = HALT;
                end
            end else begin
                instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID outputs are queued per cycle and checked after each edge.
// Memory model returns 16'h1000+addr, or F000 at one selectable address.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [5:0]  branch_offset_imm;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic        halted;

    logic        halt_en;
    logic [15:0] halt_at;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] addr;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = 16'h1000 + imem_addr;
        if (halt_en && imem_addr == halt_at) begin
            imem_rdata = 16'hF000;
        end
    end

    if_stage #(
        .RESET_PC (16'h0000),
        .HALT_OP  (4'hF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_offset_imm (branch_offset_imm),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .instr_out         (instr_out),
        .pc_out            (pc_out),
        .halted            (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".instr"},  instr_out, 32'h0000);
        chk({tag, ".pc_out"}, pc_out,    32'h0000);
        chk({tag, ".addr"},   imem_addr, 32'h0000);
        chk({tag, ".halted"}, halted,    32'h0);
    endtask

    // Drive one cycle of inputs, queue the expected outputs, check after the edge; ends on a negedge.
    task automatic step(input logic s, input logic b, input logic [5:0] o,
                        input logic [15:0] e_instr, input logic [15:0] e_pc,
                        input logic [15:0] e_addr, input logic e_halt);
        exp_t e;
        stall             = s;
        branch_taken      = b;
        branch_offset_imm = o;
        sb_q.push_back('{e_instr, e_pc, e_addr, e_halt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_txn++;
        $display("txn %0d: stall=%b br=%b off=%h -> instr=%h pc_out=%h addr=%h halted=%b",
                 n_txn, s, b, o, instr_out, pc_out, imem_addr, halted);
        chk("instr",  instr_out, e.instr);
        chk("pc_out", pc_out,    e.pc);
        chk("addr",   imem_addr, e.addr);
        chk("halted", halted,    e.halted);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset_imm = 6'd0;
        halt_en = 1'b0; halt_at = 16'h0000;
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch from RESET_PC
        step(0, 0, 6'd0, 16'h1000, 16'h0000, 16'h0001, 0);
        step(0, 0, 6'd0, 16'h1001, 16'h0001, 16'h0002, 0);
        step(0, 0, 6'd0, 16'h1002, 16'h0002, 16'h0003, 0);
        step(0, 0, 6'd0, 16'h1003, 16'h0003, 16'h0004, 0);
        step(0, 0, 6'd0, 16'h1004, 16'h0004, 16'h0005, 0);

        // Stall three cycles at pc_out=4, then release
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 6'd0, 16'h1004, 16'h0004, 16'h0005, 0);
        end
        step(0, 0, 6'd0, 16'h1005, 16'h0005, 16'h0006, 0);

        // Backward branch -3 from pc_out=5 -> target 3
        step(0, 1, 6'b111101, 16'h0000, 16'h0003, 16'h0003, 0);
        step(0, 0, 6'd0,      16'h1003, 16'h0003, 16'h0004, 0);

        // Branch wins over stall: 3+1+1 = 5
        step(1, 1, 6'b000001, 16'h0000, 16'h0005, 16'h0005, 0);
        step(0, 0, 6'd0,      16'h1005, 16'h0005, 16'h0006, 0);
        step(0, 0, 6'd0,      16'h1006, 16'h0006, 16'h0007, 0);

        // HALT opcode at address 8
        halt_en = 1'b1; halt_at = 16'h0008;
        step(0, 0, 6'd0, 16'h1007, 16'h0007, 16'h0008, 0);
        step(0, 0, 6'd0, 16'hF000, 16'h0008, 16'h0008, 1);
        step(0, 0, 6'd0, 16'h0000, 16'h0008, 16'h0008, 1);
        step(1, 0, 6'd0, 16'h0000, 16'h0008, 16'h0008, 1);
        step(0, 0, 6'd0, 16'h0000, 16'h0008, 16'h0008, 1);
        // Branch out of HALT: 8+1+4 = 13
        step(0, 1, 6'b000100, 16'h0000, 16'h000D, 16'h000D, 0);
        step(0, 0, 6'd0,      16'h100D, 16'h000D, 16'h000E, 0);

        // Branch in the same cycle a HALT opcode is fetched; offset -1 loops on itself
        halt_at = 16'h000F;
        step(0, 0, 6'd0,      16'h100E, 16'h000E, 16'h000F, 0);
        step(0, 1, 6'b111111, 16'h0000, 16'h000E, 16'h000E, 0);
        step(0, 0, 6'd0,      16'h100E, 16'h000E, 16'h000F, 0);
        step(0, 1, 6'b111111, 16'h0000, 16'h000E, 16'h000E, 0);
        halt_en = 1'b0;
        step(1, 0, 6'd0,      16'h0000, 16'h000E, 16'h000E, 0);

        // Asynchronous reset while stalled, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Wrap: 0+1-2 = FFFF, then sequential FFFF -> 0000
        step(0, 1, 6'b111110, 16'h0000, 16'hFFFF, 16'hFFFF, 0);
        step(0, 0, 6'd0,      16'h0FFF, 16'hFFFF, 16'h0000, 0);
        step(0, 0, 6'd0,      16'h1000, 16'h0000, 16'h0001, 0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, word address fetched first after reset.
REQ-002 SHALL have parameter HALT_OP, default 4'hF, opcode that stops fetch.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port stall, input, 1, hold PC and instr_out unchanged this cycle.
REQ-006 SHALL have port branch_taken, input, 1, from ID: the instruction now in ID redirects fetch.
REQ-007 SHALL have port branch_offset_imm, input, 6, from ID: signed word offset of that branch.
REQ-008 SHALL have port imem_addr, output, 16, word address to instruction memory, equals PC.
REQ-009 SHALL have port imem_rdata, input, 16, instruction at imem_addr, same cycle (combinational memory).
REQ-010 SHALL have port instr_out, output, 16, registered instruction to ID input_instr.
REQ-011 SHALL have port pc_out, output, 16, registered word address of instr_out.
REQ-012 SHALL have port halted, output, 1, high while fetch is stopped by HALT_OP.

Function
REQ-013 PC SHALL be 16-bit, word-addressed; sequential next PC = PC + 1, wrapping 16'hFFFF -> 16'h0000.
REQ-014 Branch target SHALL be pc_out + 1 + sign-extended branch_offset_imm, 16-bit modulo arithmetic.
REQ-015 States SHALL be RUN and HALT; reset enters RUN.
REQ-016 In RUN, no stall, no branch: instr_out <= imem_rdata, pc_out <= PC, PC <= PC + 1 (1-cycle fetch latency).
REQ-017 branch_taken SHALL have priority over stall and HALT: PC <= target, instr_out <= 16'h0000 (NOP), pc_out <= target, state <= RUN.
REQ-018 With stall and no branch_taken, PC, instr_out, pc_out, state SHALL hold.
REQ-019 In RUN, when imem_rdata[15:12] == HALT_OP and neither stall nor branch_taken: instr_out <= imem_rdata, pc_out <= PC, PC holds, state <= HALT.
REQ-020 In HALT without branch_taken: PC holds, instr_out <= 16'h0000 each unstalled cycle, halted = 1.
REQ-021 halted SHALL be a decode of state (1 iff HALT), no extra latency.
REQ-022 branch_taken and a fetched HALT_OP in the same cycle: branch wins, HALT ignored (wrong path).
REQ-023 Branch to current PC (offset -1) SHALL be legal and loop without error.

Reset
REQ-024 On rst: PC = RESET_PC, instr_out = 16'h0000, pc_out = RESET_PC, state = RUN, halted = 0.
REQ-025 rst mid-operation SHALL override stall, branch_taken and HALT immediately and asynchronously.
REQ-026 First cycle after rst release SHALL fetch RESET_PC.

Structure
REQ-027 Shared package SHALL hold NOP_INSTR (16'h0000), HALT_OP, opcode width 4, instruction width 16, state enum {RUN, HALT}.
REQ-028 One sub-module if_pc_gen SHALL compute next PC (sequential, branch target, hold) combinationally; FSM and output registers stay in if_stage.
REQ-029 Instruction memory SHALL be external, not instantiated here.

Verification
REQ-030 Reset, imem returns 16'h1000+addr -> instr_out 1000,1001,1002 on cycles 1-3; pc_out 0,1,2.
REQ-031 pc_out=5, branch_taken=1, offset=6'b111101 (-3) -> next cycle PC=3, instr_out=0000, pc_out=3; following cycle instr_out=mem[3].
REQ-032 stall high 3 cycles at pc_out=4 -> instr_out, pc_out frozen; release -> pc_out=5 next cycle.
REQ-033 mem[2]=F000 -> instr_out=F000 at pc_out=2, halted=1 next cycle, then NOPs, imem_addr stays 2; branch_taken offset +4 -> PC=7, halted=0.
REQ-034 stall and branch_taken together -> branch applied; same cycle as HALT_OP fetch -> halted stays 0.
REQ-035 PC=FFFF sequential -> next PC=0000; rst asserted mid-stall -> outputs at reset values without a clock edge.
